// File: rtl/rmt_pkg.sv
// Shared widths and helpers for the RMT stage pipeline.
package rmt_pkg;

    localparam int PHV_LEN              = 32*64 + 256;
    localparam int C_VLANID_WIDTH       = 12;
    localparam int C_S_AXIS_DATA_WIDTH  = 256;
    localparam int C_S_AXIS_TUSER_WIDTH = 128;
    localparam int C_S_AXIS_KEEP_WIDTH  = C_S_AXIS_DATA_WIDTH / 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    localparam int LINK_DEPTH = 4;
    localparam int LINK_CNT_W = clog2(LINK_DEPTH) + 1;

endpackage

// File: rtl/link_fifo.sv
// First-word-fall-through FIFO with registered ready, valid, count and head data.
module link_fifo
    import rmt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = clog2(DEPTH) + 1
) (
    input  logic             axis_clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] cnt
);

    localparam int PW = CNT_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             push;
    logic             pop;

    assign push       = din_valid & din_ready;
    assign pop        = dout_valid & dout_ready;
    assign rd_ptr_nxt = rd_ptr + PW'(1);
    assign cnt_nxt    = cnt + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge axis_clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            din_ready  <= 1'b1;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            cnt        <= cnt_nxt;
            din_ready  <= (cnt_nxt != CNT_W'(DEPTH));
            dout_valid <= (cnt_nxt != '0);
            // With a single entry left, the successor is not in memory yet: take it straight from din.
            if (pop) begin
                if (cnt == CNT_W'(1)) begin
                    if (push)
                        dout <= din;
                end else begin
                    dout <= mem[rd_ptr_nxt];
                end
            end else if (push && (cnt == '0)) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/stage_link_buffer.sv
// Elastic buffer between RMT stages: independent PHV/VLAN FIFOs plus a one-beat control re-timer.
module stage_link_buffer
    import rmt_pkg::*;
#(
    parameter int PHV_LEN              = rmt_pkg::PHV_LEN,
    parameter int C_VLANID_WIDTH       = rmt_pkg::C_VLANID_WIDTH,
    parameter int DEPTH                = rmt_pkg::LINK_DEPTH,
    parameter int CNT_W                = rmt_pkg::LINK_CNT_W,
    parameter int C_S_AXIS_DATA_WIDTH  = rmt_pkg::C_S_AXIS_DATA_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = rmt_pkg::C_S_AXIS_TUSER_WIDTH
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              phv_ready_out,
    input  logic [C_VLANID_WIDTH-1:0]         vlan_in,
    input  logic                              vlan_valid_in,
    output logic                              vlan_ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              phv_ready_in,
    output logic [C_VLANID_WIDTH-1:0]         vlan_out,
    output logic                              vlan_valid_out,
    input  logic                              vlan_ready_in,
    output logic [CNT_W-1:0]                  phv_cnt,
    output logic [CNT_W-1:0]                  vlan_cnt,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);

    link_fifo #(
        .WIDTH (PHV_LEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_phv_fifo (
        .axis_clk   (axis_clk),
        .aresetn    (aresetn),
        .din        (phv_in),
        .din_valid  (phv_in_valid),
        .din_ready  (phv_ready_out),
        .dout       (phv_out),
        .dout_valid (phv_out_valid),
        .dout_ready (phv_ready_in),
        .cnt        (phv_cnt)
    );

    link_fifo #(
        .WIDTH (C_VLANID_WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_vlan_fifo (
        .axis_clk   (axis_clk),
        .aresetn    (aresetn),
        .din        (vlan_in),
        .din_valid  (vlan_valid_in),
        .din_ready  (vlan_ready_out),
        .dout       (vlan_out),
        .dout_valid (vlan_valid_out),
        .dout_ready (vlan_ready_in),
        .cnt        (vlan_cnt)
    );

    // Control stream has no backpressure, so a plain pipeline register is enough.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            c_m_axis_tdata  <= c_s_axis_tdata;
            c_m_axis_tuser  <= c_s_axis_tuser;
            c_m_axis_tkeep  <= c_s_axis_tkeep;
            c_m_axis_tvalid <= c_s_axis_tvalid;
            c_m_axis_tlast  <= c_s_axis_tlast;
        end
    end

endmodule

// File: doc/stage_link_buffer.md
Name: stage_link_buffer

Overview:
- Elastic inter-stage buffer between the PHV/VLAN outputs of one RMT stage and the inputs of the next.
- Decouples the two ready/valid handshakes: PHV and VLAN ID each get an independent first-word-fall-through FIFO.
- Re-times the daisy-chained control AXI-Stream with one register stage, so long stage chains close timing.
- Exposes occupancy counts for debug.

Parameters:
- PHV_LEN, 2304, PHV width in bits (32*64+256).
- C_VLANID_WIDTH, 12, VLAN ID width.
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- CNT_W, 3, occupancy counter width, equal to log2(DEPTH)+1.
- C_S_AXIS_DATA_WIDTH, 256, control tdata width.
- C_S_AXIS_TUSER_WIDTH, 128, control tuser width.

Ports:
- axis_clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- phv_in  in  PHV_LEN  PHV from upstream stage
- phv_in_valid  in  1  PHV valid
- phv_ready_out  out  1  PHV FIFO can accept
- vlan_in  in  C_VLANID_WIDTH  VLAN ID from upstream
- vlan_valid_in  in  1  VLAN valid
- vlan_ready_out  out  1  VLAN FIFO can accept
- phv_out  out  PHV_LEN  head PHV to downstream stage
- phv_out_valid  out  1  PHV FIFO non-empty
- phv_ready_in  in  1  downstream accepts PHV
- vlan_out  out  C_VLANID_WIDTH  head VLAN ID
- vlan_valid_out  out  1  VLAN FIFO non-empty
- vlan_ready_in  in  1  downstream accepts VLAN
- phv_cnt  out  CNT_W  PHV FIFO occupancy
- vlan_cnt  out  CNT_W  VLAN FIFO occupancy
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  256/128/32/1/1  control stream in
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  256/128/32/1/1  control stream out

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - All pointers and counts go to 0.
  - phv_out_valid=0, vlan_valid_out=0.
  - phv_ready_out=1 and vlan_ready_out=1 from the first cycle after reset.
  - phv_out=0, vlan_out=0.
  - All c_m_axis_* outputs=0.
  - Reset mid-operation discards all buffered entries; no partial output.
- Push: valid_in & ready_out at a clock edge writes one entry.
- Pop: valid_out & ready_in at a clock edge removes the head.
- Push and pop are independent for the PHV FIFO and the VLAN FIFO. There is no pairing or ordering between them.
- Ready is a registered signal: ready_out = (cnt != DEPTH), driven from a flop.
  - There is no combinational path from ready_in to ready_out.
  - When full, a push is refused even if a pop happens in the same cycle. ready_out rises in the cycle after the pop.
- valid_out = (cnt != 0), driven from a flop.
  - Latency is 1 cycle: a push into an empty FIFO at edge N gives valid_out=1 with the data at edge N+1.
- Output data is the registered head entry.
  - It is stable while valid_out=1 and ready_in=0.
  - After a pop with more entries buffered, the next entry is presented in the following cycle with no bubble. Back-to-back throughput is 1 per cycle when not full.
- Simultaneous push and pop when 0<cnt<DEPTH: cnt is unchanged and both operations complete.
- Pointers are CNT_W-1 bits and wrap modulo DEPTH.
- Input while ready_out=0 is ignored. The upstream stage holds its data; no error flag is raised.
- Control path: every c_m_axis_* output is c_s_axis_* delayed by exactly 1 cycle, including tvalid=0 beats. There is no backpressure.

Decomposition:
- Shared package rmt_pkg holds PHV_LEN, C_VLANID_WIDTH, the AXIS widths and a clog2 helper constant.
- One natural sub-module: link_fifo, a parameterized WIDTH/DEPTH FWFT FIFO with registered ready, valid and count.
  - It is instantiated twice: WIDTH=PHV_LEN and WIDTH=C_VLANID_WIDTH.
- The control register stage stays inline.

Test Plan:
- Reset and idle: after reset, phv_ready_out=1, vlan_ready_out=1, both valids 0, both counts 0, c_m_axis_tvalid=0.
- Single-entry latency: push PHV with low word 0xA5 at cycle 10 and VLAN 0x123 at cycle 12, with ready_in=1.
  - phv_out_valid=1 at cycle 11 with 0xA5; popped that cycle.
  - vlan_out=0x123 valid at cycle 13.
- Fill to full: hold phv_ready_in=0 and push PHVs 1,2,3,4.
  - phv_cnt=4 and phv_ready_out=0.
  - A fifth push of 5 is ignored.
  - Release ready: outputs 1,2,3,4 on consecutive cycles; 5 is never emitted.
- Full with simultaneous pop and push: at cnt=4, assert ready_in and offer PHV 9.
  - 9 is not accepted that cycle and cnt=3.
  - ready_out=1 the next cycle; 9 is accepted and emitted after 2,3,4.
- Streaming and wrap: 20 consecutive PHVs with both readies high.
  - Output order is preserved, throughput is 1 per cycle, cnt never exceeds 1.
  - Pointers wrap 5 times without corruption.
- Reset mid-flight and control path:
  - Drive control beats tdata=0xDEAD, tlast=1; c_m_axis mirrors them exactly 1 cycle later.
  - Reset with cnt=3: all valids drop and counts read 0 on the next cycle.
